// File: rtl/spi_cfg_arbiter_if.sv
// Requester and pad-side signal bundle for spi_cfg_arbiter.
// The master modport is the arbiter itself; the slave modport is the requester/pad side.
interface spi_cfg_arbiter_if;
  logic        req0;
  logic [23:0] word0;
  logic        ack0;
  logic        req1;
  logic [23:0] word1;
  logic        ack1;
  logic [7:0]  rd_data;
  logic        busy;
  logic        owner;
  logic        sclk;
  logic        clkd_csn;
  logic        sdata_out;
  logic        sdata_oe;
  logic        sdata_in;

  modport master (
    input  req0, word0, req1, word1, sdata_in,
    output ack0, ack1, rd_data, busy, owner,
    output sclk, clkd_csn, sdata_out, sdata_oe
  );

  modport slave (
    output req0, word0, req1, word1, sdata_in,
    input  ack0, ack1, rd_data, busy, owner,
    input  sclk, clkd_csn, sdata_out, sdata_oe
  );
endinterface

// File: rtl/spi_cfg_arbiter.sv
// Two-port round-robin SPI configuration master for a 3-wire clock-distribution chip.
// Serialises 24-bit accesses MSB-first and captures the readback byte for read accesses.
module spi_cfg_arbiter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               sys_clk,
  input  logic               reset,
  spi_cfg_arbiter_if.master  bus
);

  localparam int unsigned WORD_W = 24;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned DATA_W = 8;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] BIT_OE_OFF = BIT_W'(15);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state,     state_nxt;
  logic [DIV_W-1:0]  div_cnt,   div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt,   bit_cnt_nxt;
  logic [WORD_W-1:0] shreg,     shreg_nxt;
  logic [DATA_W-1:0] cap,       cap_nxt;
  logic              is_read,   is_read_nxt;
  logic              last,      last_nxt;
  logic              owner,     owner_nxt;
  logic              busy,      busy_nxt;
  logic              ack0,      ack0_nxt;
  logic              ack1,      ack1_nxt;
  logic [DATA_W-1:0] rd_data,   rd_data_nxt;
  logic              sclk,      sclk_nxt;
  logic              csn,       csn_nxt;
  logic              sdo,       sdo_nxt;
  logic              oe,        oe_nxt;

  logic              div_end;
  logic              grant;
  logic [WORD_W-1:0] grant_word;

  assign div_end = (div_cnt == DIV_LAST);

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cap     <= '0;
      is_read <= 1'b0;
      last    <= 1'b1;
      owner   <= 1'b0;
      busy    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rd_data <= '0;
      sclk    <= 1'b0;
      csn     <= 1'b1;
      sdo     <= 1'b0;
      oe      <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      cap     <= cap_nxt;
      is_read <= is_read_nxt;
      last    <= last_nxt;
      owner   <= owner_nxt;
      busy    <= busy_nxt;
      ack0    <= ack0_nxt;
      ack1    <= ack1_nxt;
      rd_data <= rd_data_nxt;
      sclk    <= sclk_nxt;
      csn     <= csn_nxt;
      sdo     <= sdo_nxt;
      oe      <= oe_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    cap_nxt     = cap;
    is_read_nxt = is_read;
    last_nxt    = last;
    owner_nxt   = owner;
    busy_nxt    = busy;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    rd_data_nxt = rd_data;
    sclk_nxt    = sclk;
    csn_nxt     = csn;
    sdo_nxt     = sdo;
    oe_nxt      = oe;
    grant       = 1'b0;
    grant_word  = '0;

    case (state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contention goes to the port that was not served last.
          grant       = (bus.req0 && bus.req1) ? ~last : bus.req1;
          grant_word  = grant ? bus.word1 : bus.word0;
          last_nxt    = grant;
          owner_nxt   = grant;
          shreg_nxt   = grant_word;
          is_read_nxt = grant_word[WORD_W-1];
          sdo_nxt     = grant_word[WORD_W-1];
          oe_nxt      = 1'b1;
          csn_nxt     = 1'b0;
          sclk_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          sclk_nxt    = 1'b1;
          state_nxt   = S_SHIFT;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_SHIFT: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_nxt = '0;
          if (sclk) begin
            // Falling transition: present the next bit while sclk is low.
            sclk_nxt  = 1'b0;
            shreg_nxt = {shreg[WORD_W-2:0], 1'b0};
            sdo_nxt   = shreg[WORD_W-2];
            if (is_read && (bit_cnt == BIT_OE_OFF)) begin
              oe_nxt = 1'b0;
            end
          end else if (bit_cnt == BIT_LAST) begin
            state_nxt = S_HOLD;
          end else begin
            // Rising transition: the slave's readback bit is valid here.
            sclk_nxt    = 1'b1;
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            if (is_read && (bit_cnt >= BIT_OE_OFF)) begin
              cap_nxt = {cap[DATA_W-2:0], bus.sdata_in};
            end
          end
        end
      end

      S_HOLD: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          csn_nxt     = 1'b1;
          oe_nxt      = 1'b0;
          ack0_nxt    = ~owner;
          ack1_nxt    = owner;
          if (is_read) begin
            rd_data_nxt = cap;
          end
          state_nxt = S_GAP;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          busy_nxt    = 1'b0;
          state_nxt   = S_IDLE;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rd_data   = rd_data;
  assign bus.busy      = busy;
  assign bus.owner     = owner;
  assign bus.sclk      = sclk;
  assign bus.clkd_csn  = csn;
  assign bus.sdata_out = sdo;
  assign bus.sdata_oe  = oe;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Directed bench for spi_cfg_arbiter with CLK_DIV=4: timing, readback, arbitration, abort.
// A passive monitor records shifted bits and plays the readback slave.
module tb_spi_cfg_arbiter;

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  spi_cfg_arbiter_if bus ();

  spi_cfg_arbiter #(.CLK_DIV(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Monitor / slave model, sampled mid-cycle.
  logic        prev_sclk = 1'b0;
  logic        prev_csn  = 1'b1;
  logic        prev_sdo  = 1'b0;
  int          rise_cnt  = 0;
  int          sdo_viol  = 0;
  logic [23:0] mon_word  = '0;
  logic [23:0] oe_rec    = '0;
  logic [7:0]  slave_byte = 8'hA5;

  always @(negedge sys_clk) begin
    if (reset) bus.sdata_in = 1'b0;
    if (bus.clkd_csn === 1'b0 && prev_csn === 1'b1) begin
      rise_cnt = 0;
      bus.sdata_in = 1'b0;
    end
    if (bus.sclk === 1'b1 && prev_sclk === 1'b0 && bus.clkd_csn === 1'b0) begin
      rise_cnt = rise_cnt + 1;
      mon_word = {mon_word[22:0], bus.sdata_out};
      oe_rec   = {oe_rec[22:0], bus.sdata_oe};
      if (rise_cnt >= 16 && rise_cnt <= 23) bus.sdata_in = slave_byte[23 - rise_cnt];
    end
    if (bus.sdata_out !== prev_sdo && bus.sclk === 1'b1) sdo_viol = sdo_viol + 1;
    prev_sclk = bus.sclk;
    prev_csn  = bus.clkd_csn;
    prev_sdo  = bus.sdata_out;
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.word0 = '0;  bus.word1 = '0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    n_vec++;
    if ({bus.clkd_csn, bus.sclk, bus.sdata_out, bus.sdata_oe} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_pins: csn/sclk/sdo/oe got %b want 1000",
               {bus.clkd_csn, bus.sclk, bus.sdata_out, bus.sdata_oe});
    end
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.owner, bus.rd_data} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_status: ack0/ack1/busy/owner/rd got %h want 000",
               {bus.ack0, bus.ack1, bus.busy, bus.owner, bus.rd_data});
    end
  endtask

  task automatic test_single_write();
    int   first_rise = 0;
    int   ack_at = 0;
    logic csn_at_ack = 1'b0;
    logic oe_dropped = 1'b0;
    bus.word0 = 24'h000190;
    bus.req0  = 1'b1;
    for (int s = 1; s <= 400 && ack_at == 0; s++) begin
      @(negedge sys_clk);
      if (s == 1) begin
        n_vec++;
        if (bus.clkd_csn !== 1'b0 || bus.busy !== 1'b1 || bus.owner !== 1'b0) begin
          n_err++;
          $display("FAIL wr_grant: csn=%b busy=%b owner=%b want 0 1 0",
                   bus.clkd_csn, bus.busy, bus.owner);
        end
      end
      if (first_rise == 0 && bus.sclk === 1'b1) first_rise = s;
      if (bus.clkd_csn === 1'b0 && bus.sdata_oe !== 1'b1) oe_dropped = 1'b1;
      if (bus.ack0 === 1'b1) begin
        ack_at = s;
        csn_at_ack = bus.clkd_csn;
      end
    end
    bus.req0 = 1'b0;
    n_vec++;
    if (first_rise != 5) begin
      n_err++; $display("FAIL wr_first_rise: got t0+%0d want t0+5", first_rise);
    end
    n_vec++;
    if (ack_at != 201 || csn_at_ack !== 1'b1) begin
      n_err++; $display("FAIL wr_ack_time: ack at t0+%0d csn=%b want t0+201 csn=1", ack_at, csn_at_ack);
    end
    n_vec++;
    if (mon_word !== 24'h000190) begin
      n_err++; $display("FAIL wr_bits: got %h want 000190", mon_word);
    end
    n_vec++;
    if (oe_rec !== 24'hFFFFFF || oe_dropped !== 1'b0) begin
      n_err++; $display("FAIL wr_oe: rec %h dropped %b want ffffff 0", oe_rec, oe_dropped);
    end
    n_vec++;
    if (bus.rd_data !== 8'h00) begin
      n_err++; $display("FAIL wr_rd_data: got %h want 00", bus.rd_data);
    end
    repeat (3) @(negedge sys_clk);
    n_vec++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b1 || bus.clkd_csn !== 1'b1) begin
      n_err++; $display("FAIL wr_gap: ack0=%b busy=%b csn=%b want 0 1 1", bus.ack0, bus.busy, bus.clkd_csn);
    end
    @(negedge sys_clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL wr_busy_end: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_read();
    int         ack_at = 0;
    logic [7:0] rd_pre = 8'hxx;
    logic [7:0] rd_at_ack = 8'hxx;
    slave_byte = 8'hA5;
    bus.word1 = 24'h800012;
    bus.req1  = 1'b1;
    for (int s = 1; s <= 400 && ack_at == 0; s++) begin
      @(negedge sys_clk);
      if (s == 200) rd_pre = bus.rd_data;
      if (bus.ack1 === 1'b1) begin
        ack_at = s;
        rd_at_ack = bus.rd_data;
      end
    end
    bus.req1 = 1'b0;
    n_vec++;
    if (ack_at != 201 || bus.owner !== 1'b1) begin
      n_err++; $display("FAIL rd_ack: at t0+%0d owner %b want t0+201 owner 1", ack_at, bus.owner);
    end
    n_vec++;
    if (rd_pre !== 8'h00 || rd_at_ack !== 8'hA5) begin
      n_err++; $display("FAIL rd_data: before %h at ack %h want 00 a5", rd_pre, rd_at_ack);
    end
    n_vec++;
    if (oe_rec !== 24'hFFFF00) begin
      n_err++; $display("FAIL rd_oe: got %h want ffff00", oe_rec);
    end
    n_vec++;
    if (mon_word[23:8] !== 16'h8000) begin
      n_err++; $display("FAIL rd_instr: got %h want 8000", mon_word[23:8]);
    end
    for (int i = 0; i < 20 && bus.busy === 1'b1; i++) @(negedge sys_clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.sdata_oe !== 1'b0) begin
      n_err++; $display("FAIL rd_idle: busy=%b oe=%b want 0 0", bus.busy, bus.sdata_oe);
    end
  endtask

  task automatic test_back_to_back();
    int   runs[3] = '{0, 0, 0};
    int   n_runs = 0;
    int   low = 0;
    int   acks = 0;
    logic pcsn = 1'b1;
    bus.word0 = 24'h000190;
    bus.req0  = 1'b1;
    for (int s = 0; s < 1000 && n_runs < 3; s++) begin
      @(negedge sys_clk);
      if (bus.ack0 === 1'b1) acks++;
      if (bus.clkd_csn === 1'b0) low++;
      if (bus.clkd_csn === 1'b1 && pcsn === 1'b0) begin
        runs[n_runs] = low;
        n_runs++;
        low = 0;
      end
      pcsn = bus.clkd_csn;
    end
    bus.req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (runs[k] != 200) begin
        n_err++; $display("FAIL b2b_csn_low[%0d]: got %0d cycles want 200", k, runs[k]);
      end
    end
    n_vec++;
    if (acks != 3) begin
      n_err++; $display("FAIL b2b_acks: got %0d want 3", acks);
    end
    for (int i = 0; i < 20 && bus.busy === 1'b1; i++) @(negedge sys_clk);
  endtask

  task automatic test_word_change();
    int acks = 0;
    bus.word0 = 24'h123456;
    bus.req0  = 1'b1;
    for (int s = 1; s <= 450; s++) begin
      @(negedge sys_clk);
      if (s == 1) bus.word0 = 24'hFFFFFF;
      if (s == 50) bus.req0 = 1'b0;
      if (bus.ack0 === 1'b1) acks++;
    end
    n_vec++;
    if (mon_word !== 24'h123456) begin
      n_err++; $display("FAIL wc_bits: got %h want 123456", mon_word);
    end
    n_vec++;
    if (acks != 1) begin
      n_err++; $display("FAIL wc_acks: got %0d want 1", acks);
    end
    n_vec++;
    if (sdo_viol != 0) begin
      n_err++; $display("FAIL sdo_while_sclk_high: got %0d changes want 0", sdo_viol);
    end
  endtask

  task automatic test_reset_mid();
    int   rises = 0;
    int   acks = 0;
    int   low = 0;
    int   ack_at = 0;
    logic ps = 1'b0;
    bus.word0 = 24'h0A0B0C;
    bus.req0  = 1'b1;
    for (int s = 0; s < 300 && rises < 10; s++) begin
      @(negedge sys_clk);
      if (bus.sclk === 1'b1 && ps === 1'b0) rises++;
      ps = bus.sclk;
    end
    n_vec++;
    if (rises != 10) begin
      n_err++; $display("FAIL rst_mid_reach: got %0d rises want 10", rises);
    end
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge sys_clk);
    n_vec++;
    if ({bus.clkd_csn, bus.sclk, bus.sdata_oe, bus.busy, bus.ack0, bus.ack1} !== 6'b100000) begin
      n_err++;
      $display("FAIL rst_mid_pins: csn/sclk/oe/busy/ack0/ack1 got %b want 100000",
               {bus.clkd_csn, bus.sclk, bus.sdata_oe, bus.busy, bus.ack0, bus.ack1});
    end
    n_vec++;
    if (bus.rd_data !== 8'h00) begin
      n_err++; $display("FAIL rst_mid_rd: got %h want 00", bus.rd_data);
    end
    reset = 1'b0;
    for (int s = 0; s < 300; s++) begin
      @(negedge sys_clk);
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) acks++;
      if (bus.clkd_csn === 1'b0) low++;
    end
    n_vec++;
    if (acks != 0 || low != 0) begin
      n_err++; $display("FAIL rst_mid_no_retry: acks %0d csn-low %0d want 0 0", acks, low);
    end
    bus.word1 = 24'h000155;
    bus.req1  = 1'b1;
    for (int s = 1; s <= 400 && ack_at == 0; s++) begin
      @(negedge sys_clk);
      if (bus.ack1 === 1'b1) ack_at = s;
    end
    bus.req1 = 1'b0;
    n_vec++;
    if (ack_at != 201 || mon_word !== 24'h000155) begin
      n_err++; $display("FAIL rst_mid_fresh: ack t0+%0d bits %h want t0+201 000155", ack_at, mon_word);
    end
    for (int i = 0; i < 20 && bus.busy === 1'b1; i++) @(negedge sys_clk);
  endtask

  task automatic test_round_robin();
    int   order[4] = '{-1, -1, -1, -1};
    int   n_ack = 0;
    int   wide = 0;
    int   both = 0;
    int   hrun = 0;
    int   min_high = 1000;
    logic pack = 1'b0;
    logic pcsn = 1'b1;
    reset = 1'b1;
    bus.word0 = 24'h000111;
    bus.word1 = 24'h000222;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    for (int s = 0; s < 1200 && n_ack < 4; s++) begin
      @(negedge sys_clk);
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both++;
      if ((bus.ack0 === 1'b1 || bus.ack1 === 1'b1) && pack === 1'b1) wide++;
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        order[n_ack] = (bus.ack1 === 1'b1) ? 1 : 0;
        n_ack++;
      end
      pack = bus.ack0 | bus.ack1;
      if (bus.clkd_csn === 1'b1) hrun++;
      if (bus.clkd_csn === 1'b0 && pcsn === 1'b1) begin
        if (n_ack > 0 && hrun < min_high) min_high = hrun;
        hrun = 0;
      end
      pcsn = bus.clkd_csn;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (order[k] != (k % 2)) begin
        n_err++; $display("FAIL rr_order[%0d]: got port %0d want %0d", k, order[k], k % 2);
      end
    end
    n_vec++;
    if (wide != 0 || both != 0) begin
      n_err++; $display("FAIL rr_ack_pulse: wide %0d both %0d want 0 0", wide, both);
    end
    n_vec++;
    if (min_high < 5 || min_high == 1000) begin
      n_err++; $display("FAIL rr_csn_gap: got %0d cycles want >=5", min_high);
    end
    for (int i = 0; i < 20 && bus.busy === 1'b1; i++) @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_back_to_back();
    test_word_change();
    test_reset_mid();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cfg_arbiter.md
# spi_cfg_arbiter

Shared 3-wire SPI configuration master that serialises 24-bit register accesses to the board clock-distribution chip (AD9516-class: 16-bit instruction + 8-bit data) on the single `sclk`/`sdata`/`clkd_csn` bus. It arbitrates round-robin between two requesters, the power-up configuration sequencer (port 0) and the Nios GPIO/CPU bridge (port 1). It supports both writes and 3-wire readback. It sits between those requesters and the top-level `sdata` inout pad, which the top level builds from `sdata_out`/`sdata_oe`/`sdata_in`.

## Interface
Parameters:
- `CLK_DIV`, 4: `sys_clk` cycles per SCLK half-period. Legal range is 2..255.

Ports:
- `sys_clk`  in  1  25 MHz system clock; the block's only clock.
- `reset`  in  1  Reset. One clock; reset is synchronous and active-high.
- `req0`  in  1  Request from the configuration sequencer.
- `word0`  in  24  Access word for port 0. Bit 23 = R/W (1 = read), bits 22:21 = W1:W0, bits 20:8 = address, bits 7:0 = write data.
- `ack0`  out  1  One-cycle completion pulse for port 0.
- `req1`  in  1  Request from the CPU bridge.
- `word1`  in  24  Access word for port 1; same format as `word0`.
- `ack1`  out  1  One-cycle completion pulse for port 1.
- `rd_data`  out  8  Byte returned by the last read access.
- `busy`  out  1  High from grant until the end of the GAP state.
- `owner`  out  1  Index of the currently or most recently granted port.
- `sclk`  out  1  SPI clock. Idles low.
- `clkd_csn`  out  1  SPI chip select, active low.
- `sdata_out`  out  1  Serial data driven to the pad.
- `sdata_oe`  out  1  Pad output enable. 1 = drive.
- `sdata_in`  in  1  Serial data sampled from the pad.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE
  - If either request is high, grant one port and go to SETUP.
  - In the same edge, latch the granted word into the shift register, set `owner`, and set `busy`=1.
- Arbitration is round-robin on a `last` register, which resets to 1.
  - If both requests are high, grant the port other than `last`.
  - If only one request is high, grant that port.
  - On each grant, `last` ← the granted port.
- SETUP, CLK_DIV cycles:
  - `clkd_csn`=0, `sclk`=0, `sdata_oe`=1, `sdata_out`=bit 23.
- SHIFT, 24 bits MSB-first, 2·CLK_DIV cycles per bit:
  - First CLK_DIV cycles with `sclk`=1, then CLK_DIV cycles with `sclk`=0.
  - At each falling-edge transition, shift the next bit onto `sdata_out`.
  - Counters: a 5-bit bit counter (0..23) and an 8-bit divider counter.
- Read access (latched bit 23 = 1):
  - `sdata_oe` drops to 0 at the falling transition that ends bit 15, and stays 0 through bits 16..23.
  - On the `sys_clk` edge where `sclk` goes 0→1 for bits 16..23, shift `sdata_in` into an 8-bit capture register, MSB first.
- Write access: `sdata_oe` stays 1 through all 24 bits.
- HOLD, CLK_DIV cycles: `sclk`=0, `clkd_csn`=0.
- HOLD exit edge:
  - `clkd_csn` → 1 and `sdata_oe` → 0.
  - `ack<owner>` is 1 for exactly that next cycle.
  - For reads only, `rd_data` ← capture register in the same cycle. Writes leave `rd_data` unchanged.
- GAP, CLK_DIV cycles, `clkd_csn`=1. Then `busy`=0 and return to IDLE.
- Requester protocol:
  - Hold `req` high and `word` stable until `ack`.
  - Deassert `req` in the cycle after `ack`, or keep it high to queue another access.
  - A `req` that drops after grant does not abort the access; its `ack` still pulses.
  - A `word` change after grant is ignored.

## Timing
- Reset values: `clkd_csn`=1, `sclk`=0, `sdata_out`=0, `sdata_oe`=0, `ack0`=`ack1`=0, `busy`=0, `owner`=0, `rd_data`=0x00, `last`=1, state IDLE.
- Reset asserted mid-access:
  - Next cycle shows all reset values.
  - No `ack` is issued.
  - The aborted access is not retried.
- Let t0 be the edge at which IDLE samples `req`:
  - `clkd_csn` falls at t0+1.
  - First `sclk` rise at t0+1+CLK_DIV.
  - `clkd_csn` is low for exactly 50·CLK_DIV cycles.
  - `ack` and `clkd_csn` rise together at t0+1+50·CLK_DIV. With CLK_DIV=4 this is t0+201.
- `clkd_csn` high time between back-to-back accesses: at least CLK_DIV+1 cycles (GAP + one IDLE evaluation).
- Setup/hold at the slave: `sdata_out` changes only while `sclk`=0, CLK_DIV cycles before and after each rising edge.
- `busy` is registered, and is high from t0+1 through the last GAP cycle.

## Test plan
- Single write, CLK_DIV=4: `req0` with `word0`=0x000190.
  - SETUP: `clkd_csn` low at t0+1.
  - 24 SCLK rises carry bits 0000_0000_0000_0001_1001_0000.
  - `ack0` at t0+201; `sdata_oe` high throughout; `rd_data` stays 0x00.
- Read: `req1` with `word1`=0x800012, slave model drives 0xA5 on bits 16..23.
  - `sdata_oe` falls after bit 15; `ack1` pulses.
  - `rd_data`=0xA5 in the `ack1` cycle.
- Simultaneous `req0` and `req1` both held high from reset, for 4 accesses:
  - Grant order is 0,1,0,1.
  - Each `ack` is a single-cycle pulse, and `clkd_csn` is high ≥5 cycles between accesses.
- `req0` only, held high continuously: three consecutive accesses, each `clkd_csn` low for exactly 200 cycles.
- `reset` asserted at the 10th SCLK rise of an access:
  - Next cycle: `clkd_csn`=1, `sclk`=0, `sdata_oe`=0, `busy`=0.
  - No `ack`.
  - A fresh `req1` afterwards completes normally.
- `word0` changed after grant, with `req0` dropped mid-access: the transmitted bits equal the originally latched word, and `ack0` still pulses once.
